// File: rtl/pipe_skid_if.sv
// Valid/ready stream bundle. The producer side uses the master modport,
// the consumer side uses the slave modport.
interface pipe_skid_if #(
  parameter int DATA_W = 128
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input  ready);
  modport slave  (input  valid, input  data, output ready);
endinterface

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake, synchronous flush to a
// bubble value, and an optional two-entry skid buffer that keeps in_ready
// coming straight from a flop.
module pipe_skid_reg #(
  parameter int                DATA_W     = 128,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
  parameter bit                SKID       = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  pipe_skid_if.slave  in_if,
  pipe_skid_if.master out_if,
  output logic [1:0]  occupancy
);

  // EMPTY: nothing held; ONE: main valid; FULL: main and skid valid.
  typedef enum logic [1:0] {S_EMPTY = 2'd0, S_ONE = 2'd1, S_FULL = 2'd2} state_t;

  state_t            state_q, state_n;
  logic [DATA_W-1:0] main_q, main_n;
  logic [DATA_W-1:0] skid_q, skid_n;
  logic              rdy_q;
  logic [1:0]        occ_q, occ_n;
  logic              in_ready;
  logic              out_valid;
  logic              accept, consume;

  assign out_valid = (state_q != S_EMPTY);

  // in_ready: flopped in skid mode, pass-through of downstream ready otherwise.
  always_comb begin
    in_ready = SKID ? rdy_q : (!out_valid || out_if.ready);
  end

  assign accept  = in_if.valid && in_ready;
  assign consume = out_valid && out_if.ready;

  // Next-state and data movement; flush wins over any accept this cycle.
  always_comb begin
    state_n = state_q;
    main_n  = main_q;
    skid_n  = skid_q;
    if (flush) begin
      state_n = S_EMPTY;
      main_n  = BUBBLE_VAL;
      skid_n  = BUBBLE_VAL;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            state_n = S_ONE;
            main_n  = in_if.data;
          end
        end
        S_ONE: begin
          if (accept && consume) begin
            main_n = in_if.data;
          end else if (accept) begin
            // Only reachable in skid mode; single-entry mode ties accept to consume here.
            state_n = S_FULL;
            skid_n  = in_if.data;
          end else if (consume) begin
            state_n = S_EMPTY;
            main_n  = BUBBLE_VAL;
          end
        end
        S_FULL: begin
          // in_ready is low in FULL, so only the drain case matters.
          if (consume) begin
            state_n = S_ONE;
            main_n  = skid_q;
            skid_n  = BUBBLE_VAL;
          end
        end
        default: begin
          state_n = S_EMPTY;
          main_n  = BUBBLE_VAL;
          skid_n  = BUBBLE_VAL;
        end
      endcase
    end
  end

  // Occupancy follows directly from the encoded next state.
  always_comb begin
    occ_n = 2'(state_n);
  end

  // State register; reset behaves exactly like flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_EMPTY;
      main_q  <= BUBBLE_VAL;
      skid_q  <= BUBBLE_VAL;
      rdy_q   <= 1'b1;
      occ_q   <= 2'd0;
    end else begin
      state_q <= state_n;
      main_q  <= main_n;
      skid_q  <= skid_n;
      rdy_q   <= (state_n != S_FULL);
      occ_q   <= occ_n;
    end
  end

  assign in_if.ready  = in_ready;
  assign out_if.valid = out_valid;
  assign out_if.data  = main_q;
  assign occupancy    = occ_q;

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised pipeline stage register; the generalised successor to our fixed four-field inter-stage registers. Carries an arbitrary-width payload between two pipeline stages with valid/ready handshaking, synchronous flush with a configurable bubble value, and an optional two-entry skid buffer that keeps `in_ready` fully registered. It sits between any two pipeline stages (F/D, D/E, E/M, M/W) and replaces the per-stage WE/Flush registers.

## Interface
- `DATA_W`, default 128: payload width in bits; the default packs PC, Instr, RD, C as 4×32.
- `BUBBLE_VAL`, default 0: value driven on `out_data` whenever `out_valid`=0 (NOP encoding).
- `SKID`, default 1: 1 = two-entry skid buffer with registered `in_ready`; 0 = single entry with combinational `in_ready`.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `flush`  in  1  synchronous discard of all held entries.
- `in_valid`  in  1  upstream offers `in_data`.
- `in_ready`  out  1  stage can accept this cycle.
- `in_data`  in  DATA_W  upstream payload.
- `out_valid`  out  1  `out_data` holds a real entry.
- `out_ready`  in  1  downstream consumes this cycle.
- `out_data`  out  DATA_W  payload to downstream; `BUBBLE_VAL` when invalid.
- `occupancy`  out  2  number of held entries (0..2; max 1 when SKID=0).

## Operation
- Transfer rules:
  - Input accept: `in_valid && in_ready`.
  - Output consume: `out_valid && out_ready`.
- State is a main register (drives `out_data`) plus, when SKID=1, a skid register. Each has a valid bit.
- SKID=1 states: EMPTY (0 entries), ONE (main valid), FULL (main and skid valid).
  - EMPTY + accept → ONE; data loads main.
  - ONE + accept + consume → ONE; main ← `in_data`.
  - ONE + accept, no consume → FULL; skid ← `in_data`.
  - ONE + consume, no accept → EMPTY.
  - FULL + consume → ONE; main ← skid. No accept is possible in FULL.
  - `in_ready` = !skid_valid, driven directly from a flop.
- SKID=0:
  - `in_ready` = !main_valid || out_ready (combinational).
  - Accept loads main.
  - Consume with no accept → empty.
- Order is strictly FIFO; no entry is ever duplicated or dropped, except by flush or reset.
- `out_data` = `BUBBLE_VAL` whenever main is invalid. On empty, main data is reloaded to `BUBBLE_VAL`; it is never left stale.
- `flush` or `reset`:
  - Both valid bits clear; main and skid data ← `BUBBLE_VAL`.
  - Priority over any simultaneous accept: the input offered in the flush cycle is dropped, even if `in_ready` was 1.
  - Consumption in the flush cycle still counts as completed for downstream.
- `occupancy` = main_valid + skid_valid, registered.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=`BUBBLE_VAL`, `occupancy`=0.
  - `in_ready`=1 (SKID=1), or `in_ready`=1 by formula (SKID=0).
- Latency: an entry accepted at edge N appears on `out_data` with `out_valid`=1 after edge N (one cycle).
- Throughput: one transfer per cycle with `out_ready` held high, in both modes.
- SKID=1, `out_ready` deasserted with `in_valid` high: exactly one extra entry is absorbed, then `in_ready` drops the cycle after.
- FULL → `out_ready`=1: `in_ready` returns to 1 the following cycle, giving one bubble cycle upstream; output stays valid back-to-back.
- Flush asserted in FULL: next cycle EMPTY, `in_ready`=1, `out_valid`=0.
- Reset asserted mid-stream behaves exactly as flush, regardless of `out_ready`.

## Test plan
- **Reset/idle**: assert reset 2 cycles, `BUBBLE_VAL`=0 → `out_valid`=0, `out_data`=0, `in_ready`=1, `occupancy`=0.
- **Streaming**: `out_ready`=1, push 0x11, 0x22, 0x33 on consecutive cycles → `out_data` = 0x11, 0x22, 0x33 on the next three cycles, `out_valid` continuous, `occupancy`=1.
- **Skid fill/drain (SKID=1)**:
  - Push 0xA1, 0xA2, 0xA3 with `out_ready`=0 → 0xA1 held on output; 0xA2 absorbed; `in_ready`=0; 0xA3 stalled; `occupancy`=2.
  - Raise `out_ready` → order 0xA1, 0xA2, 0xA3, nothing lost.
- **Flush in FULL with simultaneous `in_valid`** (data 0xBB) → next cycle `out_valid`=0, `out_data`=`BUBBLE_VAL`, `occupancy`=0; 0xBB never appears.
- **Bubble value**: `BUBBLE_VAL`=0x00000013, drain to empty → `out_data`=0x13 while invalid.
- **SKID=0 backpressure**: `out_ready`=0 with main valid → `in_ready`=0 the same cycle; `out_ready`=1 with `in_valid`=1 → replace in place, `occupancy` stays 1.
